// File: rtl/round_timer_ctrl.sv
// Round clock sequencer for an external up/down Counter: prescales clk to ticks, issues incs, detects expiry/knockout.
// Latency: every output is registered; an inc code appears 1 cycle after the prescaler wrap, and expiry 1 cycle after count_in reaches ROUND_LEN.
// No backpressure: start/pause/ko are level inputs sampled every cycle. Optional low-time blink is enabled by ROUND_TIMER_WARN_EN.
module round_timer_ctrl #(
    parameter int W         = 7,
    parameter int TICK_DIV  = 25_000_000,
    parameter int ROUND_LEN = 99,
    parameter int WARN_LEN  = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         pause,
    input  logic         ko,
    input  logic [W-1:0] count_in,
    output logic [1:0]   cnt_ctrl,
    output logic [W-1:0] time_left,
    output logic         running,
    output logic         round_over,
    output logic         expired,
    output logic         warn
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_PAUSED,
        S_DONE
    } state_t;

    // Counter control codes
    localparam logic [1:0] CTRL_HOLD  = 2'b00;
    localparam logic [1:0] CTRL_INC   = 2'b01;
    localparam logic [1:0] CTRL_CLEAR = 2'b11;

    localparam int              PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [W-1:0]    RLEN     = W'(ROUND_LEN);

    // Reject parameter sets that would let a second inc slip in before expiry,
    // or a round length the Counter cannot represent.
    if (TICK_DIV < 3 || ROUND_LEN < 1 || ROUND_LEN >= (1 << W) || WARN_LEN < 0) begin : g_param_check
        $error("round_timer_ctrl: illegal parameter set");
    end

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] presc;
    logic          pre_wrap;
    logic          at_limit;
    logic          run_adv;
    logic [W-1:0]  time_calc;

    logic [1:0]    ctrl_nxt;
    logic          expired_nxt;
    logic          running_nxt;
    logic          over_nxt;

    assign pre_wrap  = (presc == PRE_LAST);
    // A foreign count beyond the round length counts as expiry too.
    assign at_limit  = (count_in >= RLEN);
    // The round clock only advances in RUN when nothing stops it this cycle.
    assign run_adv   = (state == S_RUN) && !ko && !at_limit && !pause;
    assign time_calc = at_limit ? '0 : (RLEN - count_in);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: ko beats expiry beats pause
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_CLEAR;
            S_CLEAR:  state_nxt = S_RUN;
            S_RUN: begin
                if (ko || at_limit) begin
                    state_nxt = S_DONE;
                end else if (pause) begin
                    state_nxt = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (ko) begin
                    state_nxt = S_DONE;
                end else if (!pause) begin
                    state_nxt = S_RUN;
                end
            end
            S_DONE:   if (start) state_nxt = S_CLEAR;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        ctrl_nxt    = CTRL_HOLD;
        expired_nxt = 1'b0;
        running_nxt = (state_nxt == S_RUN);
        over_nxt    = (state_nxt == S_DONE);
        case (state)
            S_IDLE, S_DONE: begin
                if (start) ctrl_nxt = CTRL_CLEAR;
            end
            S_RUN: begin
                if (run_adv && pre_wrap) ctrl_nxt = CTRL_INC;
                // Knockout suppresses the timeout flag even when both coincide.
                if (!ko && at_limit) expired_nxt = 1'b1;
            end
            default: ctrl_nxt = CTRL_HOLD;
        endcase
    end

    // Output registers, aligned with the state register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_ctrl   <= CTRL_HOLD;
            running    <= 1'b0;
            round_over <= 1'b0;
            expired    <= 1'b0;
        end else begin
            cnt_ctrl   <= ctrl_nxt;
            running    <= running_nxt;
            round_over <= over_nxt;
            expired    <= expired_nxt;
        end
    end

    // Prescaler: cleared in CLEAR, counts only while the round clock advances
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
        end else if (state == S_CLEAR) begin
            presc <= '0;
        end else if (run_adv) begin
            presc <= pre_wrap ? '0 : (presc + PW'(1));
        end
    end

    // Time left tracks the Counter every cycle, frozen once the round is over
    always_ff @(posedge clk) begin
        if (rst) begin
            time_left <= RLEN;
        end else if (state != S_DONE) begin
            time_left <= time_calc;
        end
    end

`ifdef ROUND_TIMER_WARN_EN
    localparam logic [PW-1:0] PRE_HALF = PW'(TICK_DIV / 2 - 1);
    localparam logic [W-1:0]  WLEN     = W'(WARN_LEN);

    // Low-time blink: toggles at each prescaler half-period, holds while paused
    always_ff @(posedge clk) begin
        if (rst) begin
            warn <= 1'b0;
        end else if (state_nxt != S_RUN && state_nxt != S_PAUSED) begin
            warn <= 1'b0;
        end else if (run_adv && (time_left <= WLEN) && (presc == PRE_HALF || pre_wrap)) begin
            warn <= ~warn;
        end
    end
`else
    assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Directed bench for round_timer_ctrl with a behavioural up/down Counter attached.
// W=4, TICK_DIV=4, ROUND_LEN=5, WARN_LEN=2; inputs driven and outputs sampled on the falling edge.
// Blink expectations follow the ROUND_TIMER_WARN_EN setting of the build.
module tb_round_timer_ctrl;

    localparam int W         = 4;
    localparam int TICK_DIV  = 4;
    localparam int ROUND_LEN = 5;
    localparam int WARN_LEN  = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         pause;
    logic         ko;
    logic [W-1:0] count;
    logic         cnt_rst;
    logic [1:0]   cnt_ctrl;
    logic [W-1:0] time_left;
    logic         running;
    logic         round_over;
    logic         expired;
    logic         warn;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    round_timer_ctrl #(
        .W(W), .TICK_DIV(TICK_DIV), .ROUND_LEN(ROUND_LEN), .WARN_LEN(WARN_LEN)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .ko(ko),
        .count_in(count), .cnt_ctrl(cnt_ctrl), .time_left(time_left),
        .running(running), .round_over(round_over), .expired(expired), .warn(warn)
    );

    // External Counter: 00 hold, 01 inc, 10 dec, 11 clear
    always_ff @(posedge clk) begin
        if (cnt_rst) begin
            count <= '0;
        end else begin
            case (cnt_ctrl)
                2'b01:   count <= count + 4'd1;
                2'b10:   count <= count - 4'd1;
                2'b11:   count <= '0;
                default: count <= count;
            endcase
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; cnt_rst = 1'b1; start = 1'b0; pause = 1'b0; ko = 1'b0;
        step();
        step();
        chk_cnt++; if (cnt_ctrl !== 2'b00) $display("FAIL reset_ctrl: got %b want 00", cnt_ctrl); else pass_cnt++;
        chk_cnt++; if (time_left !== 4'd5) $display("FAIL reset_time_left: got %0d want 5", time_left); else pass_cnt++;
        chk_cnt++; if ({running, round_over, expired, warn} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {running, round_over, expired, warn}); else pass_cnt++;
        rst = 1'b0; cnt_rst = 1'b0;
    endtask

    // Full round from IDLE or DONE; optionally holds start high mid-round.
    task automatic run_full_round(input bit start_noise);
        logic [1:0] exp_ctrl;
        logic       exp_warn;
        start = 1'b1;
        step();
        start = 1'b0;
        chk_cnt++; if (cnt_ctrl !== 2'b11) $display("FAIL round_clear_ctrl: got %b want 11", cnt_ctrl); else pass_cnt++;
        chk_cnt++; if (running !== 1'b0) $display("FAIL round_clear_running: got %b want 0", running); else pass_cnt++;
        for (int i = 0; i <= 21; i++) begin
            step();
            exp_ctrl = (i > 0 && (i % 4) == 0) ? 2'b01 : 2'b00;
`ifdef ROUND_TIMER_WARN_EN
            exp_warn = (i inside {16, 17, 20, 21});
`else
            exp_warn = 1'b0;
`endif
            chk_cnt++; if (cnt_ctrl !== exp_ctrl) $display("FAIL round_ctrl_r%0d: got %b want %b", i, cnt_ctrl, exp_ctrl); else pass_cnt++;
            chk_cnt++; if (running !== 1'b1) $display("FAIL round_running_r%0d: got %b want 1", i, running); else pass_cnt++;
            chk_cnt++; if (warn !== exp_warn) $display("FAIL round_warn_r%0d: got %b want %b", i, warn, exp_warn); else pass_cnt++;
            if (start_noise) start = (i >= 2 && i <= 10);
        end
        chk_cnt++; if (time_left !== 4'd1) $display("FAIL round_time_left_r21: got %0d want 1", time_left); else pass_cnt++;
        chk_cnt++; if (expired !== 1'b0) $display("FAIL round_expired_early: got %b want 0", expired); else pass_cnt++;
        step();
        chk_cnt++; if (expired !== 1'b1) $display("FAIL round_expired_pulse: got %b want 1", expired); else pass_cnt++;
        chk_cnt++; if (round_over !== 1'b1) $display("FAIL round_over_set: got %b want 1", round_over); else pass_cnt++;
        chk_cnt++; if (time_left !== 4'd0) $display("FAIL round_time_left_end: got %0d want 0", time_left); else pass_cnt++;
        chk_cnt++; if (running !== 1'b0) $display("FAIL round_running_end: got %b want 0", running); else pass_cnt++;
        chk_cnt++; if (count !== 4'd5) $display("FAIL round_count_end: got %0d want 5", count); else pass_cnt++;
        chk_cnt++; if (warn !== 1'b0) $display("FAIL round_warn_end: got %b want 0", warn); else pass_cnt++;
        step();
        chk_cnt++; if (expired !== 1'b0) $display("FAIL round_expired_once: got %b want 0", expired); else pass_cnt++;
        chk_cnt++; if (round_over !== 1'b1) $display("FAIL round_over_hold: got %b want 1", round_over); else pass_cnt++;
        chk_cnt++; if (cnt_ctrl !== 2'b00) $display("FAIL round_ctrl_done: got %b want 00", cnt_ctrl); else pass_cnt++;
        chk_cnt++; if (count !== 4'd5) $display("FAIL round_count_hold: got %0d want 5", count); else pass_cnt++;
    endtask

    task automatic test_timeout();
        run_full_round(1'b0);
    endtask

    task automatic test_ko();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k <= 11; k++) step();
        chk_cnt++; if (count !== 4'd2) $display("FAIL ko_count_before: got %0d want 2", count); else pass_cnt++;
        ko = 1'b1;
        step();
        ko = 1'b0;
        chk_cnt++; if (round_over !== 1'b1) $display("FAIL ko_round_over: got %b want 1", round_over); else pass_cnt++;
        chk_cnt++; if (expired !== 1'b0) $display("FAIL ko_expired: got %b want 0", expired); else pass_cnt++;
        chk_cnt++; if (time_left !== 4'd3) $display("FAIL ko_time_left: got %0d want 3", time_left); else pass_cnt++;
        chk_cnt++; if (cnt_ctrl !== 2'b00) $display("FAIL ko_no_inc: got %b want 00", cnt_ctrl); else pass_cnt++;
        for (int k = 0; k < 3; k++) step();
        chk_cnt++; if (count !== 4'd2) $display("FAIL ko_count_after: got %0d want 2", count); else pass_cnt++;
        chk_cnt++; if (time_left !== 4'd3) $display("FAIL ko_time_left_frozen: got %0d want 3", time_left); else pass_cnt++;
    endtask

    task automatic test_pause();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        pause = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk_cnt++; if (cnt_ctrl !== 2'b00) $display("FAIL pause_ctrl_%0d: got %b want 00", k, cnt_ctrl); else pass_cnt++;
            chk_cnt++; if (running !== 1'b0) $display("FAIL pause_running_%0d: got %b want 0", k, running); else pass_cnt++;
        end
        chk_cnt++; if (count !== 4'd0) $display("FAIL pause_count: got %0d want 0", count); else pass_cnt++;
        pause = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk_cnt++; if (cnt_ctrl !== ((k == 4) ? 2'b01 : 2'b00))
                $display("FAIL resume_ctrl_%0d: got %b want %b", k, cnt_ctrl, (k == 4) ? 2'b01 : 2'b00); else pass_cnt++;
            chk_cnt++; if (running !== 1'b1) $display("FAIL resume_running_%0d: got %b want 1", k, running); else pass_cnt++;
        end
    endtask

    task automatic test_reset_in_run();
        bit found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (count == 4'd3) found = 1'b1;
        end
        chk_cnt++; if (!found) $display("FAIL rst_run_wait: got count %0d want 3 within 40 cycles", count); else pass_cnt++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_cnt++; if (cnt_ctrl !== 2'b00) $display("FAIL rst_run_ctrl: got %b want 00", cnt_ctrl); else pass_cnt++;
        chk_cnt++; if (time_left !== 4'd5) $display("FAIL rst_run_time_left: got %0d want 5", time_left); else pass_cnt++;
        chk_cnt++; if ({running, round_over, expired, warn} !== 4'b0000)
            $display("FAIL rst_run_flags: got %b want 0000", {running, round_over, expired, warn}); else pass_cnt++;
        chk_cnt++; if (count !== 4'd3) $display("FAIL rst_run_count_held: got %0d want 3", count); else pass_cnt++;
        start = 1'b1;
        step();
        start = 1'b0;
        chk_cnt++; if (cnt_ctrl !== 2'b11) $display("FAIL rst_run_restart_ctrl: got %b want 11", cnt_ctrl); else pass_cnt++;
        step();
        chk_cnt++; if (count !== 4'd0) $display("FAIL rst_run_count_cleared: got %0d want 0", count); else pass_cnt++;
        chk_cnt++; if (running !== 1'b1) $display("FAIL rst_run_running: got %b want 1", running); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        ko = 1'b1;
        step();
        ko = 1'b0;
        chk_cnt++; if (round_over !== 1'b1) $display("FAIL b2b_ko_done: got %b want 1", round_over); else pass_cnt++;
        run_full_round(1'b1);
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_ko();
        test_pause();
        test_reset_in_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
